// File: rtl/uart_rx_deser_if.sv
// Signal bundle between the RXD pin side and the command-parser side of the UART receiver.
// The master modport is the deserializer; the slave modport is its environment.
interface uart_rx_deser_if #(
    parameter int DATA_BITS = 8
);
    logic                 CLK_RX;
    logic                 RXD;
    logic [DATA_BITS-1:0] DATA;
    logic                 DATA_VALID;
    logic                 FRAME_ERR;
    logic                 PARITY_ERR;
    logic                 BUSY;

    modport master (
        input  CLK_RX, RXD,
        output DATA, DATA_VALID, FRAME_ERR, PARITY_ERR, BUSY
    );

    modport slave (
        output CLK_RX, RXD,
        input  DATA, DATA_VALID, FRAME_ERR, PARITY_ERR, BUSY
    );
endinterface

// File: rtl/uart_rx_deser.sv
// UART receive deserializer: start detect, mid-bit sampling, LSB-first assembly, 1 stop bit.
// Define UART_RX_PARITY_EN to add an even-parity bit after the data bits.
module uart_rx_deser #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic            CLK,
    input  logic            RST,
    uart_rx_deser_if.master bus
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] HALF_TICK = TW'(OVERSAMPLE/2 - 1);
    localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_e;

    state_e               state_q, state_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 rst_meta_q, rst_n_q;
    logic                 rx_meta_q, rxs_q;
    logic                 bit_end;
    logic                 stop_sample;
`ifdef UART_RX_PARITY_EN
    logic                 par_q, par_d;
    logic                 perr_q, perr_d;
`endif

    // Reset asserts asynchronously but releases only on a clock edge.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rst_meta_q <= 1'b0;
            rst_n_q    <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_n_q    <= rst_meta_q;
        end
    end

    always_ff @(posedge CLK or negedge rst_n_q) begin
        if (!rst_n_q) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
            state_q   <= S_IDLE;
            tick_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q     <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            rx_meta_q <= bus.RXD;
            rxs_q     <= rx_meta_q;
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_q     <= par_d;
            perr_q    <= perr_d;
`endif
        end
    end

    assign bit_end     = bus.CLK_RX && (tick_q == LAST_TICK);
    assign stop_sample = (state_q == S_STOP) && bit_end;

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!rxs_q) begin
                    tick_d  = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bus.CLK_RX) begin
                    if (tick_q == HALF_TICK) begin
                        // Line back high at mid start bit: treat as a glitch.
                        if (rxs_q) begin
                            state_d = S_IDLE;
                        end else begin
                            tick_d  = '0;
                            bit_d   = '0;
                            state_d = S_DATA;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    tick_d  = '0;
                    shift_d = {rxs_q, shift_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end else if (bus.CLK_RX) begin
                    tick_d = tick_q + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    tick_d  = '0;
                    par_d   = rxs_q;
                    state_d = S_STOP;
                end else if (bus.CLK_RX) begin
                    tick_d = tick_q + 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    tick_d  = '0;
                    state_d = rxs_q ? S_IDLE : S_BREAK;
                end else if (bus.CLK_RX) begin
                    tick_d = tick_q + 1'b1;
                end
            end
            S_BREAK: begin
                // Wait out a held-low line so it cannot retrigger a start.
                if (rxs_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_d  = 1'b0;
`endif
        if (stop_sample) begin
            data_d  = shift_q;
            valid_d = rxs_q;
            ferr_d  = !rxs_q;
`ifdef UART_RX_PARITY_EN
            perr_d  = par_q ^ (^shift_q);
`endif
        end
    end

    assign bus.DATA       = data_q;
    assign bus.DATA_VALID = valid_q;
    assign bus.FRAME_ERR  = ferr_q;
    assign bus.BUSY       = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
    assign bus.PARITY_ERR = perr_q;
`else
    assign bus.PARITY_ERR = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_deser.sv
// Scoreboard bench for uart_rx_deser: directed frames push expected words, a monitor pops and compares.
module tb_uart_rx_deser;
    localparam int DB = 8;
    localparam int OS = 16;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_TICKS = OS * (DB + 3);
`else
    localparam int FRAME_TICKS = OS * (DB + 2);
`endif

    typedef struct {
        bit          ferr;
        logic [DB-1:0] data;
        bit          perr;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    exp_t sb[$];
    int   ev_ticks[$];
    int   checks   = 0;
    int   failures = 0;
    int   tick_cnt = 0;

    uart_rx_deser_if #(.DATA_BITS(DB)) bus ();

    uart_rx_deser #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // CLK_RX: one-cycle tick every 4 clocks.
    initial begin
        bus.CLK_RX = 1'b0;
        forever begin
            for (int p = 0; p < 4; p++) begin
                @(posedge clk);
                #1;
                bus.CLK_RX = (p == 3);
                if (p == 3) tick_cnt++;
            end
        end
    end

    always @(negedge clk) begin
        if (bus.DATA_VALID || bus.FRAME_ERR || bus.PARITY_ERR) begin
            ev_ticks.push_back(tick_cnt);
            if (sb.size() == 0) begin
                check("unexpected_pulse", {29'd0, bus.DATA_VALID, bus.FRAME_ERR, bus.PARITY_ERR}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("RX data=%02h valid=%0b ferr=%0b perr=%0b (exp data=%02h ferr=%0b perr=%0b) tick=%0d",
                         bus.DATA, bus.DATA_VALID, bus.FRAME_ERR, bus.PARITY_ERR,
                         e.data, e.ferr, e.perr, tick_cnt);
                check("pulse_kind", {30'd0, bus.DATA_VALID, bus.FRAME_ERR}, {30'd0, !e.ferr, e.ferr});
                check("rx_data", {24'd0, bus.DATA}, {24'd0, e.data});
                check("parity_err", {31'd0, bus.PARITY_ERR}, {31'd0, e.perr});
            end
        end
    end

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (bus.CLK_RX !== 1'b1) @(posedge clk);
        end
        #2;
    endtask

    task automatic send_bit(input logic b);
        bus.RXD = b;
        wait_ticks(OS);
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input logic stop_bit, input logic par_bit);
        send_bit(1'b0);
        for (int i = 0; i < DB; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(par_bit);
`else
        if (par_bit === 1'bx) $display("note: parity bit unused");
`endif
        send_bit(stop_bit);
    endtask

    task automatic push(input bit ferr, input logic [DB-1:0] d, input bit perr);
        exp_t e;
        e.ferr = ferr;
        e.data = d;
        e.perr = perr;
        sb.push_back(e);
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n0;
        bus.RXD = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_data", {24'd0, bus.DATA}, 32'd0);
        check("rst_flags", {28'd0, bus.DATA_VALID, bus.FRAME_ERR, bus.PARITY_ERR, bus.BUSY}, 32'd0);
        rst_n = 1'b1;
        wait_ticks(4);

        // Clean 0xA5 frame
        push(1'b0, 8'hA5, 1'b0);
        send_frame(8'hA5, 1'b1, ^8'hA5);
        check("idle_after_a5", {31'd0, bus.BUSY}, 32'd0);

        // 6-tick low glitch must be rejected
        bus.RXD = 1'b0;
        wait_ticks(2);
        check("glitch_busy_rise", {31'd0, bus.BUSY}, 32'd1);
        wait_ticks(4);
        bus.RXD = 1'b1;
        wait_ticks(10);
        check("glitch_busy_fall", {31'd0, bus.BUSY}, 32'd0);
        check("glitch_data_kept", {24'd0, bus.DATA}, 32'h0000_00A5);

        // 0x3C with stop bit low, line then held low
        push(1'b1, 8'h3C, 1'b0);
        send_frame(8'h3C, 1'b0, ^8'h3C);
        wait_ticks(2 * OS);
        check("break_busy", {31'd0, bus.BUSY}, 32'd1);
        check("break_data", {24'd0, bus.DATA}, 32'h0000_003C);
        bus.RXD = 1'b1;
        wait_ticks(2);
        check("break_release", {31'd0, bus.BUSY}, 32'd0);
        wait_ticks(OS);

        // Back-to-back frames, no idle gap
        n0 = ev_ticks.size();
        push(1'b0, 8'h01, 1'b0);
        push(1'b0, 8'hFF, 1'b0);
        push(1'b0, 8'h80, 1'b0);
        send_frame(8'h01, 1'b1, ^8'h01);
        send_frame(8'hFF, 1'b1, ^8'hFF);
        send_frame(8'h80, 1'b1, ^8'h80);
        wait_ticks(2);
        check("b2b_count", ev_ticks.size() - n0, 32'd3);
        if (ev_ticks.size() - n0 >= 3) begin
            check("b2b_gap1", ev_ticks[n0+1] - ev_ticks[n0], FRAME_TICKS);
            check("b2b_gap2", ev_ticks[n0+2] - ev_ticks[n0+1], FRAME_TICKS);
        end

`ifdef UART_RX_PARITY_EN
        push(1'b0, 8'h07, 1'b0);
        send_frame(8'h07, 1'b1, 1'b1);
        push(1'b0, 8'h07, 1'b1);
        send_frame(8'h07, 1'b1, 1'b0);
`endif

        // Reset during bit 4 of 0x55
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(i[0] ? 1'b0 : 1'b1);
        bus.RXD = 1'b1;
        wait_ticks(8);
        check("busy_mid_frame", {31'd0, bus.BUSY}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_data", {24'd0, bus.DATA}, 32'd0);
        check("async_rst_flags", {28'd0, bus.DATA_VALID, bus.FRAME_ERR, bus.PARITY_ERR, bus.BUSY}, 32'd0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        wait_ticks(4);
        push(1'b0, 8'h12, 1'b0);
        send_frame(8'h12, 1'b1, ^8'h12);

        for (int i = 0; i < 200 && sb.size() != 0; i++) wait_ticks(1);
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
